// File: rtl/keypad_emulator.sv
// Responder-side model of a 3x4 matrix keypad: drives active-low column lines from the scan
// select so that a requested key appears held for a fixed number of frames, then released.
module keypad_emulator #(
    parameter int unsigned HoldFrames = 4,
    parameter int unsigned GapFrames  = 2,
    parameter logic [2:0]  SelLast    = 3'b101
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] sel_i,
    input  logic       req_i,
    input  logic [3:0] key_i,
    output logic [2:0] column_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       key_err_o
);

    typedef enum logic [2:0] {StIdle, StSync, StPress, StGap, StDone} state_e;

    localparam logic [3:0] HoldLast = 4'(HoldFrames - 1);
    localparam logic [3:0] GapLast  = 4'(GapFrames - 1);

    state_e     state_q;
    logic [3:0] key_q;
    logic [3:0] cnt_q;
    logic [2:0] sel_prev_q;
    logic       busy_q;
    logic       done_q;
    logic       key_err_q;

    logic       frame_tick;
    logic       hold_end;
    logic       key_visible;
    logic [1:0] key_row;
    logic [2:0] key_col;

    assign frame_tick = (sel_prev_q == SelLast) && (sel_i == 3'b000);
    assign hold_end   = frame_tick && (cnt_q == HoldLast);

    // Key shows up in the tick cycle that starts the first frame and vanishes on the last tick.
    assign key_visible = ((state_q == StSync) && frame_tick) ||
                         ((state_q == StPress) && !hold_end);

    always_comb begin
        key_row = 2'd0;
        key_col = 3'b111;
        case (key_q)
            4'h1: begin key_row = 2'd0; key_col = 3'b011; end
            4'h2: begin key_row = 2'd0; key_col = 3'b101; end
            4'h3: begin key_row = 2'd0; key_col = 3'b110; end
            4'h4: begin key_row = 2'd1; key_col = 3'b011; end
            4'h5: begin key_row = 2'd1; key_col = 3'b101; end
            4'h6: begin key_row = 2'd1; key_col = 3'b110; end
            4'h7: begin key_row = 2'd2; key_col = 3'b011; end
            4'h8: begin key_row = 2'd2; key_col = 3'b101; end
            4'h9: begin key_row = 2'd2; key_col = 3'b110; end
            4'hA: begin key_row = 2'd3; key_col = 3'b011; end
            4'h0: begin key_row = 2'd3; key_col = 3'b101; end
            4'hB: begin key_row = 2'd3; key_col = 3'b110; end
            default: begin key_row = 2'd0; key_col = 3'b111; end
        endcase
    end

    always_comb begin
        column_o = 3'b111;
        if (key_visible && !sel_i[2] && (sel_i[1:0] == key_row)) begin
            column_o = key_col;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            key_q      <= 4'd0;
            cnt_q      <= 4'd0;
            sel_prev_q <= 3'b000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            key_err_q  <= 1'b0;
        end else begin
            sel_prev_q <= sel_i;
            done_q     <= 1'b0;
            key_err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_i) begin
                        if (key_i <= 4'hB) begin
                            key_q   <= key_i;
                            busy_q  <= 1'b1;
                            state_q <= StSync;
                        end else begin
                            key_err_q <= 1'b1;
                        end
                    end
                end
                StSync: begin
                    if (frame_tick) begin
                        cnt_q   <= 4'd0;
                        state_q <= StPress;
                    end
                end
                StPress: begin
                    if (hold_end) begin
                        cnt_q   <= 4'd0;
                        state_q <= StGap;
                    end else if (frame_tick) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StGap: begin
                    if ((GapFrames == 0) || (frame_tick && (cnt_q == GapLast))) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else if (frame_tick) begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign key_err_o = key_err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Scoreboarded bench for keypad_emulator: each accepted press pushes its expected timeline,
// a negedge monitor compares column/busy/done/key_err every cycle against the queue head.
module tb_keypad_emulator;

    localparam int H = 4;
    localparam int G = 2;

    typedef struct {
        int         acc;
        int         t0;
        int         dn;
        logic [1:0] row;
        logic [2:0] code;
    } press_t;

    logic       clk;
    logic       rst_ni;
    logic [2:0] sel_i;
    logic       req_i;
    logic [3:0] key_i;
    logic [2:0] column_o;
    logic       busy_o;
    logic       done_o;
    logic       key_err_o;

    press_t press_q[$];
    int     err_q[$];
    int     cyc;
    int     n_vec;
    int     n_err;

    keypad_emulator dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .sel_i    (sel_i),
        .req_i    (req_i),
        .key_i    (key_i),
        .column_o (column_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .key_err_o(key_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running scanner: sel advances 0..5 just after every rising edge.
    initial begin
        sel_i = 3'd0;
        cyc   = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc   = cyc + 1;
            sel_i = (sel_i == 3'd5) ? 3'd0 : sel_i + 3'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [2:0] key_code(input logic [3:0] k);
        int ci;
        if (k == 4'h0)      ci = 1;
        else if (k == 4'hA) ci = 0;
        else if (k == 4'hB) ci = 2;
        else                ci = (int'(k) - 1) % 3;
        return ~(3'b100 >> ci);
    endfunction

    function automatic logic [1:0] key_row(input logic [3:0] k);
        if (k == 4'h0 || k >= 4'hA) return 2'd3;
        return 2'((int'(k) - 1) / 3);
    endfunction

    always @(negedge clk) begin
        logic [2:0] ec;
        logic       eb;
        logic       ed;
        logic       ek;
        press_t     h;
        ec = 3'b111;
        eb = 1'b0;
        ed = 1'b0;
        ek = 1'b0;
        if (press_q.size() > 0) begin
            h  = press_q[0];
            eb = (cyc > h.acc) && (cyc < h.dn);
            ed = (cyc == h.dn);
            if (cyc >= h.t0 && cyc < h.t0 + 6 * H && sel_i == {1'b0, h.row}) ec = h.code;
        end
        if (err_q.size() > 0) ek = (err_q[0] == cyc);
        chk("column", 32'(column_o), 32'(ec));
        chk("busy", 32'(busy_o), 32'(eb));
        chk("done", 32'(done_o), 32'(ed));
        chk("key_err", 32'(key_err_o), 32'(ek));
        if (ed) void'(press_q.pop_front());
        if (ek) void'(err_q.pop_front());
    end

    // Requests are accepted only when the bench believes the DUT is idle.
    task automatic press(input logic [3:0] k);
        press_t p;
        @(posedge clk);
        #2;
        if (press_q.size() == 0 && rst_ni) begin
            if (k <= 4'hB) begin
                p.acc  = cyc;
                p.t0   = cyc + 6 - int'(sel_i);
                p.dn   = p.t0 + 6 * (H + G) + 1;
                p.row  = key_row(k);
                p.code = key_code(k);
                press_q.push_back(p);
            end else begin
                err_q.push_back(cyc + 1);
            end
        end
        req_i = 1'b1;
        key_i = k;
        @(posedge clk);
        #2;
        req_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && press_q.size() > 0; i++) @(posedge clk);
        chk("timeout", 32'(press_q.size()), 32'd0);
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_ni = 1'b0;
        req_i  = 1'b0;
        key_i  = 4'd0;
        repeat (8) @(posedge clk);
        #3 rst_ni = 1'b1;
        repeat (3) @(posedge clk);

        press(4'h2);
        wait_done();

        press(4'h6);
        repeat (10) @(posedge clk);
        press(4'h4);
        wait_done();
        press(4'h4);
        wait_done();

        press(4'hB);
        wait_done();

        press(4'hE);
        repeat (4) @(posedge clk);
        press(4'hC);
        repeat (4) @(posedge clk);

        press(4'h8);
        for (int i = 0; i < 60 && column_o == 3'b111; i++) @(negedge clk);
        chk("press_seen", 32'(column_o), 32'(3'b101));
        #2;
        rst_ni = 1'b0;
        press_q.delete();
        err_q.delete();
        #1;
        chk("rst_column", 32'(column_o), 32'(3'b111));
        chk("rst_busy", 32'(busy_o), 32'd0);
        repeat (3) @(posedge clk);
        #3 rst_ni = 1'b1;
        repeat (2) @(posedge clk);

        press(4'h5);
        wait_done();
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
